idli_alu_seq_m: RTL and testbench
=================================

Name: idli_alu_seq_m

Overview:
- Sequences one WIDTH-bit ALU operation through the 4b serial ALU datapath, least-significant nibble first.
- Accepts a request over a valid/ready handshake, registers the operands and drives one nibble per cycle to the ALU.
- Owns the ALU's last-cycle control, assembles the result nibbles and returns result plus flag over a valid/ready handshake.
- Sits between core decode/execute and the ALU instance.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.

Ports:
- i_seq_gck  in  1  clock; one clock domain.
- i_seq_rst  in  1  reset; synchronous, active-high.
- i_seq_req_vld  in  1  request valid.
- o_seq_req_rdy  out  1  request ready.
- i_seq_req_op  in  alu_op_t  requested operation.
- i_seq_req_lhs  in  WIDTH  left operand.
- i_seq_req_rhs  in  WIDTH  right operand.
- o_seq_alu_op  out  alu_op_t  op to the ALU.
- o_seq_alu_lhs  out  4  lhs nibble to the ALU.
- o_seq_alu_rhs  out  4  rhs nibble to the ALU.
- o_seq_alu_last  out  1  ALU last-cycle control; clears the ALU carry flop.
- i_seq_alu_out  in  4  ALU result nibble.
- i_seq_alu_cout  in  1  ALU carry/predicate output.
- o_seq_res_vld  out  1  result valid.
- i_seq_res_rdy  in  1  result ready.
- o_seq_res_data  out  WIDTH  assembled result.
- o_seq_res_flag  out  1  final carry (ADD) or predicate (OR_PUTP), else 0.
- o_seq_busy  out  1  high in RUN or DONE.

Behaviour:
- Reset:
  - Any cycle with i_seq_rst high: next state IDLE; nibble counter 0; o_seq_res_vld 0; o_seq_res_data 0; o_seq_res_flag 0.
  - Reset mid-RUN or mid-DONE aborts the operation with no result.
  - Reset has priority over every handshake.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_seq_req_rdy=1.
  - On vld&rdy: capture op/lhs/rhs, counter←0, go to RUN.
- RUN:
  - Drive o_seq_alu_lhs/rhs from bits [3:0] of the operand registers and o_seq_alu_op from the op register.
  - Each cycle: shift the operand registers right by 4; shift the result register right by 4 with i_seq_alu_out entering [WIDTH-1:WIDTH-4]; counter+1.
  - When counter = NIBBLES-1, where NIBBLES = WIDTH/4: go to DONE.
  - Flag capture: ADD takes i_seq_alu_cout on the final nibble. OR_PUTP takes i_seq_alu_cout on nibble 0, which is result bit 0. AND/XOR give 0.
- DONE:
  - o_seq_res_vld=1.
  - Data and flag are held stable until i_seq_res_rdy.
  - o_seq_req_rdy = i_seq_res_rdy.
  - On res handshake with a simultaneous req handshake: capture the new request, go to RUN. Otherwise go to IDLE.
- o_seq_alu_last:
  - Equals (state≠RUN) OR (counter = NIBBLES-1).
  - It is therefore high in IDLE, DONE and reset, so the ALU carry is 0 on nibble 0 of every operation.
  - No carry leaks between back-to-back operations.
- o_seq_alu_op/lhs/rhs outside RUN: drive the registered values. The ALU output is ignored then.
- Latency and throughput:
  - Request accepted at edge E, so o_seq_res_vld rises after edge E+NIBBLES (16b: 4 RUN cycles).
  - Throughput with res_rdy tied high: one op per NIBBLES+1 cycles.
- Width rules: all arithmetic is modulo 2^WIDTH. Carry out appears only in o_seq_res_flag.
- Simultaneous events: o_seq_req_vld while RUN is not accepted (rdy=0); the requester holds the request.
- Reset-state outputs: o_seq_res_vld=0, o_seq_req_rdy=1 in the first cycle after reset, o_seq_busy=0, o_seq_alu_last=1.

Decomposition:
- alu_op_t and its encodings ALU_OP_ADD/AND/OR_PUTP/XOR stay in idli_pkg.
- Add to idli_pkg:
  - seq_state_t enum {SEQ_IDLE, SEQ_RUN, SEQ_DONE}.
  - Localparam NIBBLE_W=4.
- No sub-module; the operand and result shift registers are inline.
- The bench instantiates the existing serial ALU and wires it to the o_seq_alu_*/i_seq_alu_* ports.

Test Plan:
- ADD 0x00FF+0x0001, res_rdy=1 → res_data 0x0100, flag 0; res_vld rises exactly 4 cycles after accept.
- ADD 0xFFFF+0x0001, then back-to-back ADD 0x0000+0x0000 → 0x0000 flag 1, then 0x0000 flag 0, proving carry isolation. o_seq_alu_last is high on every nibble-3 cycle and in IDLE.
- AND 0xF0F0&0x3C3C → 0x3030 flag 0; XOR 0xAAAA^0xFFFF → 0x5555 flag 0; OR_PUTP 0x1200|0x0001 → 0x1201 flag 1; OR_PUTP 0x0010|0x0100 → 0x0110 flag 0.
- Backpressure: res_rdy=0 for 5 cycles in DONE → res_vld, data and flag stable; req_rdy=0 throughout; a new req_vld is held. On res_rdy=1 both handshakes complete in the same cycle and the next op enters RUN.
- Reset asserted on nibble 2 of ADD 0x1234+0x1111 → next cycle IDLE, res_vld never rises, data 0. A following ADD 0x0001+0x0001 → 0x0002 flag 0.
- Random ops and operands against a reference model, with req_vld and res_rdy randomly toggled → every result matches, no requests are lost or duplicated, and no handshake occurs while RUN.

Source files
------------

// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types for the idli core ALU path.
package idli_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD     = 2'd0,
        ALU_OP_AND     = 2'd1,
        ALU_OP_OR_PUTP = 2'd2,
        ALU_OP_XOR     = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/idli_alu.sv
// rtl/idli_alu.sv - 4b serial ALU; carry flop chains nibbles, last clears it.
module idli_alu
    import idli_pkg::*;
(
    input  logic         i_alu_gck,
    input  logic         i_alu_rst,
    input  alu_op_t      i_alu_op,
    input  logic [3:0]   i_alu_lhs,
    input  logic [3:0]   i_alu_rhs,
    input  logic         i_alu_last,
    output logic [3:0]   o_alu_out,
    output logic         o_alu_cout
);

    logic       carry_q;
    logic [4:0] sum;

    assign sum = {1'b0, i_alu_lhs} + {1'b0, i_alu_rhs} + {4'b0, carry_q};

    always_comb begin
        o_alu_out  = 4'b0;
        o_alu_cout = 1'b0;
        case (i_alu_op)
            ALU_OP_ADD: begin
                o_alu_out  = sum[3:0];
                o_alu_cout = sum[4];
            end
            ALU_OP_AND: o_alu_out = i_alu_lhs & i_alu_rhs;
            ALU_OP_OR_PUTP: begin
                // Predicate is bit 0 of the OR result; meaningful on nibble 0 only.
                o_alu_out  = i_alu_lhs | i_alu_rhs;
                o_alu_cout = i_alu_lhs[0] | i_alu_rhs[0];
            end
            ALU_OP_XOR: o_alu_out = i_alu_lhs ^ i_alu_rhs;
            default: begin
                o_alu_out  = 4'b0;
                o_alu_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_alu_gck) begin
        if (i_alu_rst || i_alu_last || i_alu_op != ALU_OP_ADD) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= o_alu_cout;
        end
    end

endmodule

// File: rtl/idli_alu_seq_m.sv
// rtl/idli_alu_seq_m.sv - sequences one WIDTH-bit op through the 4b serial ALU, LS nibble first.
module idli_alu_seq_m
    import idli_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               i_seq_gck,
    input  logic               i_seq_rst,
    input  logic               i_seq_req_vld,
    output logic               o_seq_req_rdy,
    input  alu_op_t            i_seq_req_op,
    input  logic [WIDTH-1:0]   i_seq_req_lhs,
    input  logic [WIDTH-1:0]   i_seq_req_rhs,
    output alu_op_t            o_seq_alu_op,
    output logic [3:0]         o_seq_alu_lhs,
    output logic [3:0]         o_seq_alu_rhs,
    output logic               o_seq_alu_last,
    input  logic [3:0]         i_seq_alu_out,
    input  logic               i_seq_alu_cout,
    output logic               o_seq_res_vld,
    input  logic               i_seq_res_rdy,
    output logic [WIDTH-1:0]   o_seq_res_data,
    output logic               o_seq_res_flag,
    output logic               o_seq_busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    seq_state_t        state;
    logic [CNT_W-1:0]  cnt;
    alu_op_t           op_q;
    logic [WIDTH-1:0]  lhs_q;
    logic [WIDTH-1:0]  rhs_q;
    logic [WIDTH-1:0]  res_q;
    logic              flag_q;
    logic              last_nib;
    logic              req_fire;

    assign last_nib       = (cnt == CNT_LAST);
    assign o_seq_req_rdy  = (state == SEQ_IDLE) || (state == SEQ_DONE && i_seq_res_rdy);
    assign req_fire       = i_seq_req_vld && o_seq_req_rdy;
    assign o_seq_res_vld  = (state == SEQ_DONE);
    assign o_seq_busy     = (state != SEQ_IDLE);
    // Held high outside RUN so the ALU carry is always clear on nibble 0.
    assign o_seq_alu_last = (state != SEQ_RUN) || last_nib;
    assign o_seq_alu_op   = op_q;
    assign o_seq_alu_lhs  = lhs_q[NIBBLE_W-1:0];
    assign o_seq_alu_rhs  = rhs_q[NIBBLE_W-1:0];
    assign o_seq_res_data = res_q;
    assign o_seq_res_flag = flag_q;

    always_ff @(posedge i_seq_gck) begin
        if (i_seq_rst) begin
            state  <= SEQ_IDLE;
            cnt    <= '0;
            op_q   <= ALU_OP_ADD;
            lhs_q  <= '0;
            rhs_q  <= '0;
            res_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE, SEQ_DONE: begin
                    if (req_fire) begin
                        op_q   <= i_seq_req_op;
                        lhs_q  <= i_seq_req_lhs;
                        rhs_q  <= i_seq_req_rhs;
                        cnt    <= '0;
                        flag_q <= 1'b0;
                        state  <= SEQ_RUN;
                    end else if (state == SEQ_DONE && i_seq_res_rdy) begin
                        state  <= SEQ_IDLE;
                    end
                end
                SEQ_RUN: begin
                    lhs_q <= {NIBBLE_W'(0), lhs_q[WIDTH-1:NIBBLE_W]};
                    rhs_q <= {NIBBLE_W'(0), rhs_q[WIDTH-1:NIBBLE_W]};
                    res_q <= {i_seq_alu_out, res_q[WIDTH-1:NIBBLE_W]};
                    cnt   <= cnt + CNT_W'(1);
                    if (op_q == ALU_OP_ADD && last_nib) begin
                        flag_q <= i_seq_alu_cout;
                    end else if (op_q == ALU_OP_OR_PUTP && cnt == '0) begin
                        flag_q <= i_seq_alu_cout;
                    end
                    if (last_nib) begin
                        state <= SEQ_DONE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idli_alu_seq_m.sv
// tb/tb_idli_alu_seq_m.sv - directed and randomised checks of the ALU sequencer with the serial ALU.
module tb_idli_alu_seq_m;
    import idli_pkg::*;

    localparam int W   = 16;
    localparam int NIB = W / 4;
    localparam int NRAND = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld;
    logic          req_rdy;
    alu_op_t       req_op;
    logic [W-1:0]  req_lhs;
    logic [W-1:0]  req_rhs;
    alu_op_t       alu_op;
    logic [3:0]    alu_lhs;
    logic [3:0]    alu_rhs;
    logic          alu_last;
    logic [3:0]    alu_out;
    logic          alu_cout;
    logic          res_vld;
    logic          res_rdy;
    logic [W-1:0]  res_data;
    logic          res_flag;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idli_alu_seq_m #(.WIDTH(W)) dut (
        .i_seq_gck      (clk),
        .i_seq_rst      (rst),
        .i_seq_req_vld  (req_vld),
        .o_seq_req_rdy  (req_rdy),
        .i_seq_req_op   (req_op),
        .i_seq_req_lhs  (req_lhs),
        .i_seq_req_rhs  (req_rhs),
        .o_seq_alu_op   (alu_op),
        .o_seq_alu_lhs  (alu_lhs),
        .o_seq_alu_rhs  (alu_rhs),
        .o_seq_alu_last (alu_last),
        .i_seq_alu_out  (alu_out),
        .i_seq_alu_cout (alu_cout),
        .o_seq_res_vld  (res_vld),
        .i_seq_res_rdy  (res_rdy),
        .o_seq_res_data (res_data),
        .o_seq_res_flag (res_flag),
        .o_seq_busy     (busy)
    );

    idli_alu alu (
        .i_alu_gck  (clk),
        .i_alu_rst  (rst),
        .i_alu_op   (alu_op),
        .i_alu_lhs  (alu_lhs),
        .i_alu_rhs  (alu_rhs),
        .i_alu_last (alu_last),
        .o_alu_out  (alu_out),
        .o_alu_cout (alu_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input alu_op_t op, input logic [W-1:0] l, input logic [W-1:0] r);
        req_vld = 1'b1;
        req_op  = op;
        req_lhs = l;
        req_rhs = r;
        #1;
        chk("req_rdy_at_send", 32'(req_rdy), 32'd1);
        cyc();
        req_vld = 1'b0;
    endtask

    task automatic run_nibbles(input string tag);
        for (int i = 0; i < NIB; i++) begin
            chk({tag, "_vld_low"}, 32'(res_vld), 32'd0);
            chk({tag, "_alu_last"}, 32'(alu_last), 32'(i == NIB - 1));
            cyc();
        end
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] d, input logic f);
        chk({tag, "_vld"}, 32'(res_vld), 32'd1);
        chk({tag, "_data"}, 32'(res_data), 32'(d));
        chk({tag, "_flag"}, 32'(res_flag), 32'(f));
    endtask

    task automatic one_op(input string tag, input alu_op_t op, input logic [W-1:0] l,
                          input logic [W-1:0] r, input logic [W-1:0] d, input logic f);
        send(op, l, r);
        run_nibbles(tag);
        check_res(tag, d, f);
        cyc();
        chk({tag, "_idle_last"}, 32'(alu_last), 32'd1);
        chk({tag, "_idle_vld"}, 32'(res_vld), 32'd0);
    endtask

    function automatic logic [W:0] model(input alu_op_t op, input logic [W-1:0] l, input logic [W-1:0] r);
        logic [W-1:0] v;
        case (op)
            ALU_OP_ADD:     return {1'b0, l} + {1'b0, r};
            ALU_OP_AND:     return {1'b0, l & r};
            ALU_OP_XOR:     return {1'b0, l ^ r};
            default: begin
                v = l | r;
                return {v[0], v};
            end
        endcase
    endfunction

    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    logic       acc;
    int         issued;
    int         accepted;
    int         got;

    initial begin
        rst     = 1'b1;
        req_vld = 1'b0;
        req_op  = ALU_OP_ADD;
        req_lhs = '0;
        req_rhs = '0;
        res_rdy = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_last", 32'(alu_last), 32'd1);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_flag", 32'(res_flag), 32'd0);

        one_op("add_00ff", ALU_OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0);

        // Back-to-back: second request taken in the DONE cycle of the first.
        send(ALU_OP_ADD, 16'hFFFF, 16'h0001);
        run_nibbles("add_ffff");
        check_res("add_ffff", 16'h0000, 1'b1);
        send(ALU_OP_ADD, 16'h0000, 16'h0000);
        run_nibbles("add_zero");
        check_res("add_zero", 16'h0000, 1'b0);
        cyc();

        one_op("and", ALU_OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
        one_op("xor", ALU_OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0);
        one_op("orp1", ALU_OP_OR_PUTP, 16'h1200, 16'h0001, 16'h1201, 1'b1);
        one_op("orp0", ALU_OP_OR_PUTP, 16'h0010, 16'h0100, 16'h0110, 1'b0);

        // Backpressure with a waiting request.
        send(ALU_OP_ADD, 16'h0003, 16'h0004);
        res_rdy = 1'b0;
        run_nibbles("bp");
        req_vld = 1'b1;
        req_op  = ALU_OP_AND;
        req_lhs = 16'h00FF;
        req_rhs = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_res("bp_hold", 16'h0007, 1'b0);
            chk("bp_req_rdy", 32'(req_rdy), 32'd0);
            cyc();
        end
        res_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(req_rdy), 32'd1);
        cyc();
        req_vld = 1'b0;
        run_nibbles("bp_next");
        check_res("bp_next", 16'h000F, 1'b0);
        cyc();

        // Reset on nibble 2 aborts the op.
        send(ALU_OP_ADD, 16'h1234, 16'h1111);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(res_data), 32'd0);
        chk("abort_flag", 32'(res_flag), 32'd0);
        chk("abort_last", 32'(alu_last), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_vld", 32'(res_vld), 32'd0);
            cyc();
        end
        one_op("post_abort", ALU_OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0);

        // Random traffic with toggled handshakes.
        issued   = 0;
        accepted = 0;
        got      = 0;
        for (int c = 0; c < 4000 && got < NRAND; c++) begin
            @(negedge clk);
            if (busy && !res_vld) chk("rand_no_req_in_run", 32'(req_rdy), 32'd0);
            acc = req_vld && req_rdy;
            if (acc) begin
                exp_q.push_back(model(req_op, req_lhs, req_rhs));
                accepted++;
            end
            if (res_vld && res_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("rand_data", 32'(res_data), 32'(exp_v[W-1:0]));
                    chk("rand_flag", 32'(res_flag), 32'(exp_v[W]));
                end
                got++;
            end
            cyc();
            if (acc) req_vld = 1'b0;
            if (!req_vld && issued < NRAND && $urandom_range(1, 0) == 1) begin
                req_op  = alu_op_t'(2'($urandom_range(3, 0)));
                req_lhs = W'($urandom);
                req_rhs = W'($urandom);
                req_vld = 1'b1;
                issued++;
            end
            res_rdy = ($urandom_range(3, 0) != 0);
        end
        chk("rand_got_all", 32'(got), 32'(NRAND));
        chk("rand_accepted", 32'(accepted), 32'(NRAND));
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
